// File: rtl/vec_memory_bus_fifo.sv
// vec_memory_bus_fifo: two independent packet FIFOs, one for requests
// (read/write) and one for responses (read_response/write_response).
// Packet layout, MSB first: {type[1:0], source[ID_W-1:0], address, payload}.
// Packets whose type does not belong on a channel are dropped, and they set
// the sticky type_err flag.
// Optional feature: define VEC_MEMORY_BUS_BYPASS_EN to let a packet fall
// through an empty FIFO combinationally. When the macro is undefined there is
// one cycle of latency and no in-to-out combinational path.
module vec_memory_bus_fifo #(
  parameter int DATA_W = 64,
  parameter int ID_W   = 4,
  parameter int DEPTH  = 4,
  localparam int PKT_W = 2 + ID_W + 2 * DATA_W,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_in_valid,
  input  logic [PKT_W-1:0] req_in_pkt,
  output logic             req_in_ready,
  output logic             req_out_valid,
  output logic [PKT_W-1:0] req_out_pkt,
  input  logic             req_out_ready,
  input  logic             rsp_in_valid,
  input  logic [PKT_W-1:0] rsp_in_pkt,
  output logic             rsp_in_ready,
  output logic             rsp_out_valid,
  output logic [PKT_W-1:0] rsp_out_pkt,
  input  logic             rsp_out_ready,
  output logic [CW-1:0]    req_count,
  output logic [CW-1:0]    rsp_count,
  output logic             type_err
);

  localparam int AW = $clog2(DEPTH);

  // Per-channel views of the ports: index 0 is the request side, index 1 is
  // the response side.
  logic             in_valid_w  [2];
  logic [PKT_W-1:0] in_pkt_w    [2];
  logic             in_ready_w  [2];
  logic             out_valid_w [2];
  logic [PKT_W-1:0] out_pkt_w   [2];
  logic             out_ready_w [2];
  logic [CW-1:0]    count_w     [2];
  logic             err_w       [2];

  assign in_valid_w[0]  = req_in_valid;
  assign in_pkt_w[0]    = req_in_pkt;
  assign out_ready_w[0] = req_out_ready;
  assign in_valid_w[1]  = rsp_in_valid;
  assign in_pkt_w[1]    = rsp_in_pkt;
  assign out_ready_w[1] = rsp_out_ready;

  assign req_in_ready  = in_ready_w[0];
  assign req_out_valid = out_valid_w[0];
  assign req_out_pkt   = out_pkt_w[0];
  assign req_count     = count_w[0];
  assign rsp_in_ready  = in_ready_w[1];
  assign rsp_out_valid = out_valid_w[1];
  assign rsp_out_pkt   = out_pkt_w[1];
  assign rsp_count     = count_w[1];
  assign type_err      = err_w[0] | err_w[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      // The type MSB selects the channel: it is 0 for read/write and 1 for
      // the two response types.
      localparam logic RSP_SIDE = (gi == 1);

      logic [PKT_W-1:0] mem [DEPTH];
      logic [AW-1:0]    wr_ptr_reg;
      logic [AW-1:0]    rd_ptr_reg;
      logic [CW-1:0]    count_reg;
      logic             err_reg;

      logic legal;
      logic empty;
      logic full;
      logic accept;
      logic push;
      logic pop;
      logic bad;

      assign legal  = (in_pkt_w[gi][PKT_W-1] == RSP_SIDE);
      assign empty  = (count_reg == '0);
      assign full   = (count_reg == CW'(DEPTH));
      assign accept = in_valid_w[gi] && !full;
      assign bad    = accept && !legal;

`ifdef VEC_MEMORY_BUS_BYPASS_EN
      logic bypass;
      // A legal packet offered to an empty FIFO is shown straight away. If the
      // consumer takes it in the same cycle, it is never written to storage.
      assign bypass          = empty && in_valid_w[gi] && legal;
      assign out_valid_w[gi] = !empty || bypass;
      assign out_pkt_w[gi]   = empty ? in_pkt_w[gi] : mem[rd_ptr_reg];
      assign pop             = !empty && out_ready_w[gi];
      assign push            = accept && legal && !(bypass && out_ready_w[gi]);
`else
      assign out_valid_w[gi] = !empty;
      assign out_pkt_w[gi]   = mem[rd_ptr_reg];
      assign pop             = !empty && out_ready_w[gi];
      assign push            = accept && legal;
`endif

      assign in_ready_w[gi] = !full;
      assign count_w[gi]    = count_reg;
      assign err_w[gi]      = err_reg;

      // Write the accepted packet into storage. The storage has no reset
      // because valid data is tracked by the pointers and the count.
      always_ff @(posedge clk) begin
        if (push) begin
          mem[wr_ptr_reg] <= in_pkt_w[gi];
        end
      end

      // Update the pointers, the occupancy and the sticky illegal-type flag.
      // Reset takes priority over any push or pop in the same cycle.
      always_ff @(posedge clk) begin
        if (reset) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
          err_reg    <= 1'b0;
        end else begin
          if (push) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
          end
          if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
          end
          case ({push, pop})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
          endcase
          if (bad) begin
            err_reg <= 1'b1;
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_vec_memory_bus_fifo.sv
// Directed self-checking bench for vec_memory_bus_fifo (default parameters).
// Expectations follow VEC_MEMORY_BUS_BYPASS_EN when it is defined.
module tb_vec_memory_bus_fifo;
  localparam int DATA_W = 64;
  localparam int ID_W   = 4;
  localparam int DEPTH  = 4;
  localparam int PKT_W  = 2 + ID_W + 2 * DATA_W;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_in_valid, req_in_ready, req_out_valid, req_out_ready;
  logic [PKT_W-1:0] req_in_pkt, req_out_pkt;
  logic             rsp_in_valid, rsp_in_ready, rsp_out_valid, rsp_out_ready;
  logic [PKT_W-1:0] rsp_in_pkt, rsp_out_pkt;
  logic [CW-1:0]    req_count, rsp_count;
  logic             type_err;

  int tests = 0;
  int fails = 0;

  vec_memory_bus_fifo #(.DATA_W(DATA_W), .ID_W(ID_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req_in_valid(req_in_valid), .req_in_pkt(req_in_pkt), .req_in_ready(req_in_ready),
    .req_out_valid(req_out_valid), .req_out_pkt(req_out_pkt), .req_out_ready(req_out_ready),
    .rsp_in_valid(rsp_in_valid), .rsp_in_pkt(rsp_in_pkt), .rsp_in_ready(rsp_in_ready),
    .rsp_out_valid(rsp_out_valid), .rsp_out_pkt(rsp_out_pkt), .rsp_out_ready(rsp_out_ready),
    .req_count(req_count), .rsp_count(rsp_count), .type_err(type_err)
  );

  always #5 clk = ~clk;

  function automatic logic [PKT_W-1:0] mkpkt(input logic [1:0] t, input logic [ID_W-1:0] src,
                                              input logic [DATA_W-1:0] addr,
                                              input logic [DATA_W-1:0] data);
    return {t, src, addr, data};
  endfunction

  function automatic logic [DATA_W-1:0] addr_of(input logic [PKT_W-1:0] p);
    return p[2*DATA_W-1:DATA_W];
  endfunction

  function automatic logic [DATA_W-1:0] data_of(input logic [PKT_W-1:0] p);
    return p[DATA_W-1:0];
  endfunction

  task automatic chk(input string tag, input logic [PKT_W-1:0] obs, input logic [PKT_W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge; inputs are then driven 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    req_in_valid = 0; req_in_pkt = '0; req_out_ready = 0;
    rsp_in_valid = 0; rsp_in_pkt = '0; rsp_out_ready = 0;
    step(); step();
    reset = 1'b0;
    #1;
    chk("rst_req_in_ready", PKT_W'(req_in_ready), 1);
    chk("rst_req_out_valid", PKT_W'(req_out_valid), 0);
    chk("rst_rsp_in_ready", PKT_W'(rsp_in_ready), 1);
    chk("rst_rsp_out_valid", PKT_W'(rsp_out_valid), 0);
    chk("rst_req_count", PKT_W'(req_count), 0);
    chk("rst_rsp_count", PKT_W'(rsp_count), 0);
    chk("rst_type_err", PKT_W'(type_err), 0);
    $display("[TB] reset checked");

    // Fill: four reads with addresses 0x10..0x13 and no pops.
    for (int i = 0; i < DEPTH; i++) begin
      step();
      req_in_valid = 1;
      req_in_pkt = mkpkt(2'd0, 4'h1, DATA_W'(64'h10 + i), DATA_W'(64'h100 + i));
      if (i == 1) begin
        #1;
        chk("latency_valid", PKT_W'(req_out_valid), 1);
        chk("latency_addr", PKT_W'(addr_of(req_out_pkt)), 'h10);
      end
      $display("[TB] push addr %0h", 16'h10 + i);
    end
    step();
    req_in_valid = 0;
    #1;
    chk("full_count", PKT_W'(req_count), 4);
    chk("full_in_ready", PKT_W'(req_in_ready), 0);

    // Drain: the addresses must come out in order.
    req_out_ready = 1;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      chk("drain_valid", PKT_W'(req_out_valid), 1);
      chk("drain_addr", PKT_W'(addr_of(req_out_pkt)), PKT_W'(64'h10 + i));
      $display("[TB] pop addr %0h", addr_of(req_out_pkt));
      step();
    end
    req_out_ready = 0;
    #1;
    chk("drain_empty_valid", PKT_W'(req_out_valid), 0);
    chk("drain_empty_count", PKT_W'(req_count), 0);

    // Streaming: preload two entries, then push and pop together for 10 cycles.
    for (int i = 0; i < 2; i++) begin
      req_in_valid = 1;
      req_in_pkt = mkpkt(2'd1, 4'h2, DATA_W'(64'h20 + i), DATA_W'(64'h200 + i));
      step();
    end
    req_out_ready = 1;
    for (int i = 0; i < 10; i++) begin
      req_in_pkt = mkpkt(2'd1, 4'h2, DATA_W'(64'h22 + i), DATA_W'(64'h222 + i));
      #1;
      chk("stream_addr", PKT_W'(addr_of(req_out_pkt)), PKT_W'(64'h20 + i));
      step();
      chk("stream_count", PKT_W'(req_count), 2);
      $display("[TB] stream cycle %0d count %0d", i, req_count);
    end
    req_in_valid = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("stream_tail_addr", PKT_W'(addr_of(req_out_pkt)), PKT_W'(64'h2A + i));
      step();
    end
    req_out_ready = 0;
    #1;
    chk("stream_end_valid", PKT_W'(req_out_valid), 0);

    // An illegal type on the request side is dropped and sets the sticky flag.
    req_in_valid = 1;
    req_in_pkt = mkpkt(2'd2, 4'h3, 64'h40, 64'h400);
    step();
    req_in_valid = 0;
    #1;
    chk("illegal_req_count", PKT_W'(req_count), 0);
    chk("illegal_req_valid", PKT_W'(req_out_valid), 0);
    chk("illegal_type_err", PKT_W'(type_err), 1);
    for (int i = 0; i < 5; i++) step();
    chk("type_err_sticky", PKT_W'(type_err), 1);
    $display("[TB] illegal request type dropped, type_err=%0d", type_err);
    reset = 1;
    step();
    reset = 0;
    #1;
    chk("type_err_cleared", PKT_W'(type_err), 0);

    // Response channel: a legal write_response is stored, and an illegal
    // type 1 is dropped.
    rsp_in_valid = 1;
    rsp_in_pkt = mkpkt(2'd3, 4'h5, 64'h50, 64'hBEEF);
    step();
    rsp_in_pkt = mkpkt(2'd1, 4'h5, 64'h51, 64'h1111);
    step();
    rsp_in_valid = 0;
    #1;
    chk("rsp_count", PKT_W'(rsp_count), 1);
    chk("rsp_head", rsp_out_pkt, mkpkt(2'd3, 4'h5, 64'h50, 64'hBEEF));
    chk("rsp_type_err", PKT_W'(type_err), 1);
    chk("rsp_req_untouched", PKT_W'(req_count), 0);
    $display("[TB] rsp channel head %0h", data_of(rsp_out_pkt));
    rsp_out_ready = 1;
    step();
    rsp_out_ready = 0;
    #1;
    chk("rsp_drained", PKT_W'(rsp_out_valid), 0);
    reset = 1;
    step();
    reset = 0;

    // Full FIFO with a push and a pop in the same cycle: the pop happens and
    // the push is refused.
    for (int i = 0; i < DEPTH; i++) begin
      req_in_valid = 1;
      req_in_pkt = mkpkt(2'd0, 4'h6, DATA_W'(64'h30 + i), 64'h0);
      step();
    end
    req_in_pkt = mkpkt(2'd0, 4'h6, 64'h34, 64'h0);
    req_out_ready = 1;
    #1;
    chk("fullpp_in_ready", PKT_W'(req_in_ready), 0);
    step();
    req_in_valid = 0;
    req_out_ready = 0;
    #1;
    chk("fullpp_count", PKT_W'(req_count), 3);
    chk("fullpp_in_ready_next", PKT_W'(req_in_ready), 1);
    chk("fullpp_head", PKT_W'(addr_of(req_out_pkt)), 'h31);
    $display("[TB] full push+pop count %0d", req_count);

    // Reset while three entries are held, with a push offered in that cycle.
    reset = 1;
    req_in_valid = 1;
    req_in_pkt = mkpkt(2'd0, 4'h7, 64'h60, 64'h0);
    step();
    reset = 0;
    req_in_valid = 0;
    #1;
    chk("midrst_count", PKT_W'(req_count), 0);
    chk("midrst_out_valid", PKT_W'(req_out_valid), 0);
    chk("midrst_in_ready", PKT_W'(req_in_ready), 1);

    // Write with payload 0xDEAD into an empty FIFO while the consumer is ready.
    req_in_valid = 1;
    req_out_ready = 1;
    rsp_out_ready = 1;
    req_in_pkt = mkpkt(2'd1, 4'h8, 64'h70, 64'hDEAD);
    #1;
`ifdef VEC_MEMORY_BUS_BYPASS_EN
    chk("bypass_valid", PKT_W'(req_out_valid), 1);
    chk("bypass_payload", PKT_W'(data_of(req_out_pkt)), 'hDEAD);
    step();
    req_in_valid = 0;
    #1;
    chk("bypass_count", PKT_W'(req_count), 0);
    chk("bypass_after_valid", PKT_W'(req_out_valid), 0);
`else
    chk("nobypass_valid", PKT_W'(req_out_valid), 0);
    step();
    req_in_valid = 0;
    req_out_ready = 0;
    #1;
    chk("nobypass_next_valid", PKT_W'(req_out_valid), 1);
    chk("nobypass_next_payload", PKT_W'(data_of(req_out_pkt)), 'hDEAD);
    chk("nobypass_count", PKT_W'(req_count), 1);
`endif
    $display("[TB] 0xDEAD write checked, req_count=%0d", req_count);
    req_out_ready = 0;
    rsp_out_ready = 0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vec_memory_bus_fifo.md
VEC_MEMORY_BUS_FIFO -- requirements
Module: vec_memory_bus_fifo

Interface
REQ-001 The block SHALL have parameter DATA_W, default 64, giving the address and payload width in bits.
REQ-002 The block SHALL have parameter ID_W, default 4, giving the source BusID width.
REQ-003 The block SHALL have parameter DEPTH, default 4, a power of two of at least 2, giving the entries per channel FIFO.
REQ-004 PKT_W SHALL equal 2+ID_W+2*DATA_W, packed as {type[1:0], source, address, payload}, MSB first; type 0=read, 1=write, 2=read_response, 3=write_response.
REQ-005 The block SHALL use one clock, and reset SHALL be synchronous and active-high.
REQ-006 clk  in  1  the single clock; all state changes on its rising edge.
REQ-007 reset  in  1  synchronous, active-high.
REQ-008 req_in_valid  in  1  producer offers a request packet.
REQ-009 req_in_pkt  in  PKT_W  request packet.
REQ-010 req_in_ready  out  1  request FIFO can accept.
REQ-011 req_out_valid  out  1  request FIFO head is valid.
REQ-012 req_out_pkt  out  PKT_W  request FIFO head.
REQ-013 req_out_ready  in  1  consumer takes the head.
REQ-014 rsp_in_valid / rsp_in_pkt / rsp_in_ready  in/in/out  1/PKT_W/1  response push side, same semantics as REQ-008..010.
REQ-015 rsp_out_valid / rsp_out_pkt / rsp_out_ready  out/out/in  1/PKT_W/1  response pop side, same semantics as REQ-011..013.
REQ-016 req_count, rsp_count  out  $clog2(DEPTH)+1  occupancy of each FIFO.
REQ-017 type_err  out  1  sticky flag: an illegal packet type was offered.

Function
REQ-018 A push SHALL occur when in_valid && in_ready, and a pop SHALL occur when out_valid && out_ready; both SHALL be evaluated at the rising clk edge.
REQ-019 in_ready SHALL equal (count != DEPTH) and SHALL NOT depend combinationally on out_ready.
REQ-020 out_valid SHALL equal (count != 0), and out_pkt SHALL show the oldest entry; out_pkt is don't-care while out_valid is 0.
REQ-021 Each FIFO SHALL be in-order; read and write pointers SHALL be log2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-022 On a simultaneous push and pop, count SHALL be unchanged and both pointers SHALL advance.
REQ-023 When full, in_ready SHALL be 0; a same-cycle pop SHALL NOT allow a push that cycle, and in_ready SHALL return to 1 on the next cycle.
REQ-024 When empty, out_valid SHALL be 0, and out_ready SHALL be ignored without underflow.
REQ-025 The request FIFO SHALL accept only types 0 and 1, and the response FIFO SHALL accept only types 2 and 3.
REQ-026 An illegal type with in_valid && in_ready SHALL be dropped: no push, count unchanged, and type_err set to 1 on the next edge.
REQ-027 type_err SHALL stay at 1 until reset.
REQ-028 With bypass disabled, latency SHALL be one cycle: a packet pushed at edge N SHALL be visible on out_pkt after edge N.
REQ-029 The two channels SHALL be fully independent, with no shared state other than clk/reset.

Reset
REQ-030 When reset is high at an edge, both pointers, both counts and type_err SHALL clear to 0.
REQ-031 The cycle after reset, in_ready SHALL be 1 and out_valid SHALL be 0 on both channels.
REQ-032 Reset SHALL take priority over a push or pop in the same cycle, and any packets held when reset asserts mid-operation SHALL be discarded.
REQ-033 FIFO storage SHALL NOT need reset.

Configuration
REQ-034 Macro VEC_MEMORY_BUS_BYPASS_EN SHALL control fall-through bypass.
REQ-035 With VEC_MEMORY_BUS_BYPASS_EN defined and a FIFO empty, out_valid SHALL equal (in_valid && legal type), and out_pkt SHALL equal in_pkt combinationally.
REQ-036 In that bypass case, a same-cycle out_ready SHALL consume the packet with no store, count staying 0; without out_ready the packet SHALL be stored normally.
REQ-037 With VEC_MEMORY_BUS_BYPASS_EN undefined, behaviour SHALL be strictly per REQ-028, with no in-to-out combinational path.

Verification
REQ-038 Bench SHALL cover: after reset, push DEPTH=4 reads with addresses 0x10..0x13 and no pops -> req_count=4, req_in_ready=0; then pop 4 -> addresses come out 0x10,0x11,0x12,0x13 in order, req_out_valid=0 afterwards.
REQ-039 Bench SHALL cover: 10 cycles of continuous push and pop at count=2 -> count stays 2, pointers wrap at least twice, output order preserved.
REQ-040 Bench SHALL cover: push of type 2 on the request side -> req_count unchanged, type_err=1 next cycle and still 1 after 5 idle cycles; reset -> type_err=0.
REQ-041 Bench SHALL cover: full FIFO with push and pop in the same cycle -> pop occurs, push is refused, req_count=3, req_in_ready=1 next cycle.
REQ-042 Bench SHALL cover: reset asserted at req_count=3 -> next cycle req_count=0, req_out_valid=0, req_in_ready=1.
REQ-043 Bench SHALL cover, with VEC_MEMORY_BUS_BYPASS_EN defined: empty FIFO, push write payload 0xDEAD with rsp_out_ready/req_out_ready=1 -> req_out_pkt payload 0xDEAD in the same cycle and req_count stays 0; undefined -> appears one cycle later.
